// File: rtl/flux_interval_reader.sv
// ---------------------------------------------------------------------------
// flux_interval_reader
//
// Measures the spacing, in CLKEN-qualified clock cycles, between flux
// transitions on the drive read-data line and tags index pulses. Each
// measurement is written as a timing word into a small event queue. The queue
// is drained one word per clock towards the acquisition FIFO.
//
// Word format: DATA[DATA_W-1] is the index flag. DATA[DATA_W-2:0] holds the
// interval count. When the interval timer reaches all-ones, an all-ones
// "carry" word is emitted and the count restarts. The sum of the words between
// two data events therefore equals their spacing.
//
// Parameters
//   DATA_W       output word width (MSB = index flag)
//   QDEPTH       event queue depth in words (power of two, >= 4)
//   SYNC_STAGES  synchroniser flops per asynchronous input (>= 2)
//
// Ports
//   CLOCK         system clock
//   RESET_N       asynchronous active-low reset
//   CLKEN         timebase enable; sampling and timing advance only when high
//   RUN           acquisition enable
//   FD_RDDATA_IN  raw read-data pulses (async, active-high)
//   FD_INDEX_IN   raw index pulses (async, active-high)
//   FIFO_FULL     downstream FIFO full; holds off WRITE
//   OVERRUN_CLR   clears OVERRUN
//   DATA          timing word, valid while WRITE is high
//   WRITE         one-cycle FIFO write strobe
//   OVERRUN       sticky: queue overflowed and words were dropped
// ---------------------------------------------------------------------------
module flux_interval_reader #(
    parameter int DATA_W      = 8,
    parameter int QDEPTH      = 4,
    parameter int SYNC_STAGES = 2
) (
    input  logic              CLOCK,
    input  logic              RESET_N,
    input  logic              CLKEN,
    input  logic              RUN,
    input  logic              FD_RDDATA_IN,
    input  logic              FD_INDEX_IN,
    input  logic              FIFO_FULL,
    input  logic              OVERRUN_CLR,
    output logic [DATA_W-1:0] DATA,
    output logic              WRITE,
    output logic              OVERRUN
);

    localparam int COUNT_W = DATA_W - 1;
    localparam int PTR_W   = $clog2(QDEPTH);
    localparam int CNT_W   = PTR_W + 1;

    localparam logic [COUNT_W-1:0] CARRY = '1;

    // Up to three pushes can fit when the queue has this much room. The
    // count of pushes is clamped to the free space. Anything beyond that is
    // dropped.
    function automatic logic [1:0] fit_pushes(input logic [1:0]       want,
                                              input logic [CNT_W-1:0] room);
        if ({{(CNT_W-2){1'b0}}, want} > room)
            return room[1:0];
        else
            return want;
    endfunction

    logic                   active;
    logic [SYNC_STAGES-1:0] data_sync_p0;
    logic [SYNC_STAGES-1:0] index_sync_p0;
    logic                   data_edge_p1;
    logic                   index_edge_p1;
    logic                   data_rise;
    logic                   index_rise;

    logic [COUNT_W-1:0]     timer;
    logic [COUNT_W-1:0]     timer_next;
    logic                   carry_hit;
    logic [DATA_W-1:0]      data_word;
    logic [DATA_W-1:0]      index_word;

    logic [DATA_W-1:0]      push_word [3];
    logic [1:0]             num_push;
    logic [1:0]             accept;
    logic                   drop;

    logic [DATA_W-1:0]      mem [QDEPTH];
    logic [PTR_W-1:0]       wr_ptr;
    logic [PTR_W-1:0]       rd_ptr;
    logic [CNT_W-1:0]       count;
    logic [CNT_W-1:0]       free;
    logic                   pop;
    logic                   run_q;

    assign active = CLKEN && RUN;

    // ---- stage p0/p1: input synchronisers and rising-edge flops ----------
    // RUN low flushes the chains. A line that is already high when RUN rises
    // is therefore seen as a fresh rising edge.
    always_ff @(posedge CLOCK or negedge RESET_N) begin
        if (!RESET_N) begin
            data_sync_p0  <= '0;
            index_sync_p0 <= '0;
            data_edge_p1  <= 1'b0;
            index_edge_p1 <= 1'b0;
        end else if (!RUN) begin
            data_sync_p0  <= '0;
            index_sync_p0 <= '0;
            data_edge_p1  <= 1'b0;
            index_edge_p1 <= 1'b0;
        end else if (CLKEN) begin
            data_sync_p0  <= {data_sync_p0[SYNC_STAGES-2:0], FD_RDDATA_IN};
            index_sync_p0 <= {index_sync_p0[SYNC_STAGES-2:0], FD_INDEX_IN};
            data_edge_p1  <= data_sync_p0[SYNC_STAGES-1];
            index_edge_p1 <= index_sync_p0[SYNC_STAGES-1];
        end
    end

    assign data_rise  = active && data_sync_p0[SYNC_STAGES-1]  && !data_edge_p1;
    assign index_rise = active && index_sync_p0[SYNC_STAGES-1] && !index_edge_p1;

    // ---- stage p2: interval timer and word generation ---------------------
    // The order matters. The carry check restarts the count first. A data
    // edge then stores the remainder. An index edge in the same cycle follows
    // and sees the count already cleared by the data edge.
    always_comb begin
        timer_next = timer + 1'b1;
        carry_hit  = 1'b0;
        data_word  = '0;
        index_word = '0;
        if (timer_next == CARRY) begin
            carry_hit  = active;
            timer_next = '0;
        end
        data_word = {1'b0, timer_next};
        if (data_rise)
            timer_next = '0;
        index_word = {1'b1, timer_next};
        if (index_rise)
            timer_next = '0;
    end

    always_ff @(posedge CLOCK or negedge RESET_N) begin
        if (!RESET_N)
            timer <= '0;
        else if (!RUN)
            timer <= '0;
        else if (CLKEN)
            timer <= timer_next;
    end

    // Pack the enabled pushes into consecutive slots, keeping the order
    // carry, data, index.
    always_comb begin
        push_word[0] = index_word;
        push_word[1] = index_word;
        push_word[2] = index_word;
        if (carry_hit)
            push_word[0] = {1'b0, CARRY};
        else if (data_rise)
            push_word[0] = data_word;
        if (carry_hit && data_rise)
            push_word[1] = data_word;
        num_push = {1'b0, carry_hit} + {1'b0, data_rise} + {1'b0, index_rise};
    end

    // ---- event queue ------------------------------------------------------
    // The drain runs every clock, regardless of CLKEN and RUN. A pop in the
    // same cycle counts as free space. A full queue can therefore still
    // accept one word when it is also being read.
    assign pop    = (count != '0) && !FIFO_FULL;
    assign free   = CNT_W'(QDEPTH) - count + CNT_W'(pop);
    assign accept = fit_pushes(num_push, free);
    assign drop   = ({{(CNT_W-2){1'b0}}, num_push} > free);

    always_ff @(posedge CLOCK) begin
        for (int k = 0; k < 3; k++) begin
            if (2'(k) < accept)
                mem[wr_ptr + PTR_W'(k)] <= push_word[k];
        end
    end

    // ---- output stage: FIFO write port and overrun flag --------------------
    always_ff @(posedge CLOCK or negedge RESET_N) begin
        if (!RESET_N) begin
            wr_ptr  <= '0;
            rd_ptr  <= '0;
            count   <= '0;
            DATA    <= '0;
            WRITE   <= 1'b0;
            OVERRUN <= 1'b0;
            run_q   <= 1'b0;
        end else begin
            wr_ptr <= wr_ptr + PTR_W'(accept);
            count  <= count + CNT_W'(accept) - CNT_W'(pop);
            WRITE  <= pop;
            run_q  <= RUN;
            if (pop) begin
                DATA   <= mem[rd_ptr];
                rd_ptr <= rd_ptr + 1'b1;
            end
            // A drop in the same cycle as a clear leaves the flag set, so the
            // loss is never hidden.
            if (drop)
                OVERRUN <= 1'b1;
            else if (OVERRUN_CLR || (RUN && !run_q))
                OVERRUN <= 1'b0;
        end
    end

endmodule
